pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 131 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid pipeline register with flush and drop counter
//
// Purpose:
//   Breaks the ready path between an upstream and a downstream valid/ready
//   interface while keeping full throughput. A main entry drives the output.
//   A skid entry catches the beat that was accepted while the main entry was
//   stalled. Flush discards everything held or offered in that cycle. It also
//   reports the discard as a registered pulse and counts the dropped beats.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   upstream beat present
//   in_data    in   upstream payload [DATA_W]
//   in_ready   out  stage accepts a beat this cycle
//   out_valid  out  registered beat present downstream
//   out_data   out  registered payload [DATA_W]
//   out_ready  in   downstream consumes the beat this cycle
//   flush      in   discard held and incoming beats
//   flush_out  out  one-cycle pulse after each flushed edge
//   occupancy  out  beats held (0..2)
//   drop_cnt   out  saturating count of beats discarded by flush [CNT_W]

module pipe_skid_reg #(
  parameter int DATA_W        = 32,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic              flush_out,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Two extra bits let the sum hold the saturated maximum plus 3 dropped beats.
  localparam int            SUM_W   = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              flush_out_q,  flush_out_d;
  logic [CNT_W-1:0]  drop_cnt_q,   drop_cnt_d;

  logic              xfer_in;
  logic              xfer_out;
  logic [1:0]        drop_add;
  logic [SUM_W-1:0]  drop_sum;

  // Ready depends only on registered skid state. Flush is the one combinational gate.
  assign in_ready  = !skid_valid_q && !flush;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = main_valid_q && out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign flush_out = flush_out_q;
  assign drop_cnt  = drop_cnt_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // A beat offered during flush counts as dropped even though in_ready is 0.
  assign drop_add = {1'b0, main_valid_q} + {1'b0, skid_valid_q} + {1'b0, in_valid};
  assign drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_add);

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    flush_out_d  = flush;
    drop_cnt_d   = drop_cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      if (ZERO_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
      if (drop_sum > CNT_MAX) begin
        drop_cnt_d = CNT_MAX[CNT_W-1:0];
      end else begin
        drop_cnt_d = drop_sum[CNT_W-1:0];
      end
    end else if (!main_valid_q || xfer_out) begin
      // Main is free this edge. The older skid beat goes first to keep order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (xfer_in) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (xfer_in) begin
      // Main is stalled. Park the accepted beat in the skid entry.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      flush_out_q  <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      flush_out_q  <= flush_out_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard testbench for pipe_skid_reg

module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // u0: default parameters
  logic        iv0, ir0, ov0, ord0, fl0, fo0;
  logic [31:0] id0, od0;
  logic [1:0]  occ0;
  logic [7:0]  dc0;

  // u1: 2-bit drop counter
  logic        iv1, ir1, ov1, ord1, fl1, fo1;
  logic [7:0]  id1, od1;
  logic [1:0]  occ1;
  logic [1:0]  dc1;

  // u2: data kept on flush
  logic        iv2, ir2, ov2, ord2, fl2, fo2;
  logic [7:0]  id2, od2;
  logic [1:0]  occ2;
  logic [7:0]  dc2;

  pipe_skid_reg u0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
    .out_valid(ov0), .out_data(od0), .out_ready(ord0), .flush(fl0),
    .flush_out(fo0), .occupancy(occ0), .drop_cnt(dc0)
  );

  pipe_skid_reg #(.DATA_W(8), .ZERO_ON_FLUSH(1'b1), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(ord1), .flush(fl1),
    .flush_out(fo1), .occupancy(occ1), .drop_cnt(dc1)
  );

  pipe_skid_reg #(.DATA_W(8), .ZERO_ON_FLUSH(1'b0), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_ready(ord2), .flush(fl2),
    .flush_out(fo2), .occupancy(occ2), .drop_cnt(dc2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for u0. It holds the beats the stage should be holding.
  logic [31:0] sb_q[$];
  logic [31:0] exp_data = '0;
  int          exp_drop = 0;

  // One clock of u0. Call it at posedge+1. It returns at the next posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] id, input logic ord, input logic fl);
    logic        exp_rdy;
    logic [31:0] e;
    iv0 = iv; id0 = id; ord0 = ord; fl0 = fl;
    #1;
    exp_rdy = (sb_q.size() < 2) && !fl;
    chk("in_ready", ir0, exp_rdy);
    if (fl) begin
      exp_drop = exp_drop + sb_q.size() + (iv ? 1 : 0);
      if (exp_drop > 255) exp_drop = 255;
      sb_q.delete();
      exp_data = '0;
    end else begin
      if (sb_q.size() > 0 && ord) begin
        e = sb_q.pop_front();
        chk("out_beat", od0, e);
      end
      if (iv && exp_rdy) sb_q.push_back(id);
      if (sb_q.size() > 0) exp_data = sb_q[0];
    end
    @(posedge clk);
    #1;
    chk("out_valid", ov0, sb_q.size() > 0);
    chk("occupancy", occ0, sb_q.size());
    chk("out_data", od0, exp_data);
    chk("flush_out", fo0, fl);
    chk("drop_cnt", dc0, exp_drop);
  endtask

  int exp_sat;

  initial begin
    reset = 1'b1;
    iv0 = 0; id0 = '0; ord0 = 0; fl0 = 0;
    iv1 = 0; id1 = '0; ord1 = 0; fl1 = 0;
    iv2 = 0; id2 = '0; ord2 = 0; fl2 = 0;
    #12;
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_data", od0, 0);
    chk("rst_occupancy", occ0, 0);
    chk("rst_flush_out", fo0, 0);
    chk("rst_drop_cnt", dc0, 0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", ir0, 1);
    @(posedge clk);
    #1;

    // Streaming at full throughput
    cycle(1, 32'h10, 1, 0);
    cycle(1, 32'h11, 1, 0);
    cycle(1, 32'h12, 1, 0);
    cycle(0, 32'h0,  1, 0);

    // Backpressure fills the skid entry and then drains in order
    cycle(1, 32'hA0, 0, 0);
    cycle(1, 32'hA1, 0, 0);
    cycle(1, 32'hA2, 0, 0);
    cycle(0, 32'h0,  1, 0);
    cycle(0, 32'h0,  1, 0);
    cycle(0, 32'h0,  1, 0);

    // Flush a full stage with a beat offered
    cycle(1, 32'hB0, 0, 0);
    cycle(1, 32'hB1, 0, 0);
    cycle(1, 32'hB2, 0, 1);
    cycle(0, 32'h0,  0, 0);

    // Back-to-back flushes give back-to-back pulses
    cycle(1, 32'hC0, 0, 0);
    cycle(0, 32'h0,  0, 1);
    cycle(0, 32'h0,  0, 1);
    cycle(0, 32'h0,  1, 0);

    // Random traffic with occasional flush
    for (int i = 0; i < 80; i++) begin
      cycle($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset with two beats held
    cycle(0, 32'h0,  0, 1);
    cycle(1, 32'hD0, 0, 0);
    cycle(1, 32'hD1, 0, 0);
    chk("pre_rst_occ", occ0, 2);
    iv0 = 0; ord0 = 0; fl0 = 0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", ov0, 0);
    chk("arst_out_data", od0, 0);
    chk("arst_occupancy", occ0, 0);
    chk("arst_drop_cnt", dc0, 0);
    chk("arst_flush_out", fo0, 0);
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete(); exp_data = '0; exp_drop = 0;
    #1;
    chk("arst_in_ready", ir0, 1);
    @(posedge clk);
    #1;
    cycle(1, 32'hE0, 1, 0);
    cycle(0, 32'h0,  1, 0);

    // Saturating drop counter, CNT_W=2
    exp_sat = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); iv1 = 1; id1 = 8'(k * 2); ord1 = 0; fl1 = 0;
      @(negedge clk); id1 = 8'(k * 2 + 1);
      @(negedge clk); iv1 = 0; fl1 = 1;
      chk("sat_pre_occ", occ1, 2);
      @(negedge clk); fl1 = 0;
      exp_sat = (exp_sat + 2 > 3) ? 3 : exp_sat + 2;
      chk("sat_drop_cnt", dc1, exp_sat);
      chk("sat_occ", occ1, 0);
    end

    // Flush without zeroing keeps the payload
    @(negedge clk); iv2 = 1; id2 = 8'h55; ord2 = 0; fl2 = 0;
    @(negedge clk); iv2 = 0; fl2 = 1;
    chk("nz_pre_valid", ov2, 1);
    @(negedge clk); fl2 = 0;
    chk("nz_out_valid", ov2, 0);
    chk("nz_out_data", od2, 8'h55);
    chk("nz_flush_out", fo2, 1);
    chk("nz_drop_cnt", dc2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
